serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor: computes A − B one bit per clock, LSB first, through a single one-bit full-subtractor cell and a registered borrow. It is the inverse-operation counterpart of the lab's ripple full-adder datapath. It trades WIDTH cycles of latency for one arithmetic cell, and exchanges operands and results over valid/ready handshakes.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 161 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with the outgoing borrow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell plus a registered borrow.
// Optional signed-overflow output is compiled in with SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    sub_state_e         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               bit_d_s;
    logic               bit_bout_s;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (bit_d_s),
        .bout (bit_bout_s)
    );

    // Next-state logic for the FSM, datapath shifts and handshake flags.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        br_d        = br_q;
        cnt_d       = cnt_q;
        borrow_d    = borrow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    br_d       = 1'b0;
                    cnt_d      = {CNT_W{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = b[WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = {bit_d_s, res_q[WIDTH-1:1]};
                br_d  = bit_bout_s;
                // Compare before incrementing so the counter never reaches WIDTH.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    borrow_d    = bit_bout_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d       = (a_msb_q != b_msb_q) && (bit_d_s != a_msb_q);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            br_q        <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            br_q        <= br_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign diff       = res_q;
    assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 8), hand-computed expectations.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic       overflow;
`endif

    int vectors;
    int miscompares;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands and return 1 time unit after the accept edge.
    task automatic apply(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("in_ready_after_accept", in_ready, 0);
    endtask

    task automatic wait_done();
        repeat (7) @(posedge clk);
        #1;
        check("out_valid_early", out_valid, 0);
        @(posedge clk);
        #1;
        check("out_valid_at_lat", out_valid, 1);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_out_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = 8'h00;
        b           = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 8'h00);
        check("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_overflow", overflow, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Basic subtraction with exact latency.
        apply(8'h5A, 8'h23);
        wait_done();
        check("5A-23_diff", diff, 8'h37);
        check("5A-23_borrow", borrow_out, 0);
        drain();

        apply(8'h10, 8'h20);
        wait_done();
        check("10-20_diff", diff, 8'hF0);
        check("10-20_borrow", borrow_out, 1);
        drain();

        apply(8'hFF, 8'hFF);
        wait_done();
        check("FF-FF_diff", diff, 8'h00);
        check("FF-FF_borrow", borrow_out, 0);
        drain();
        check("idle_holds_diff", diff, 8'h00);

        apply(8'h00, 8'hFF);
        wait_done();
        check("00-FF_diff", diff, 8'h01);
        check("00-FF_borrow", borrow_out, 1);
        drain();
        check("idle_holds_result", diff, 8'h01);

        // Backpressure with stray in_valid pulses in RUN and DONE.
        apply(8'h9C, 8'h4E);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_out_valid", out_valid, 1);
        check("bp_diff", diff, 8'h4E);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            @(posedge clk);
            #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_diff", diff, 8'h4E);
            check("bp_hold_borrow", borrow_out, 0);
            check("bp_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("bp_no_restart", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);

        // Back-to-back: 10 cycles per result.
        @(negedge clk);
        a = 8'h03;
        b = 8'h01;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h01;
        b = 8'h03;
        repeat (8) @(posedge clk);
        #1;
        check("b2b1_valid", out_valid, 1);
        check("b2b1_diff", diff, 8'h02);
        check("b2b1_borrow", borrow_out, 0);
        check("b2b1_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("b2b_idle_valid", out_valid, 0);
        check("b2b_idle_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("b2b_accept2", in_ready, 0);
        repeat (7) @(posedge clk);
        #1;
        check("b2b2_early", out_valid, 0);
        @(posedge clk);
        #1;
        check("b2b2_valid", out_valid, 1);
        check("b2b2_diff", diff, 8'hFE);
        check("b2b2_borrow", borrow_out, 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b_end_valid", out_valid, 0);
        check("b2b_end_ready", in_ready, 1);

        // Asynchronous reset in the middle of RUN.
        apply(8'h5A, 8'h23);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_diff", diff, 8'h00);
        check("mid_rst_borrow", borrow_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h40, 8'h01);
        wait_done();
        check("40-01_diff", diff, 8'h3F);
        check("40-01_borrow", borrow_out, 0);
        drain();

`ifdef SERIAL_SUB_OVF_EN
        apply(8'h80, 8'h01);
        wait_done();
        check("80-01_diff", diff, 8'h7F);
        check("80-01_ovf", overflow, 1);
        check("80-01_borrow", borrow_out, 0);
        drain();

        apply(8'h7F, 8'hFF);
        wait_done();
        check("7F-FF_diff", diff, 8'h80);
        check("7F-FF_ovf", overflow, 1);
        check("7F-FF_borrow", borrow_out, 1);
        drain();

        apply(8'h05, 8'h03);
        wait_done();
        check("05-03_diff", diff, 8'h02);
        check("05-03_ovf", overflow, 0);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
